// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and the round-robin pick helper for the SDRAM read-port arbiter.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_st_t;

    // The helper works on a fixed 8-wide request vector, which covers N = 2..8
    localparam int RR_MAX = 8;
    localparam int RR_IW  = 3;

    typedef struct packed {
        logic             valid;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First set bit scanning ptr, ptr+1, ... wrapping at n by compare-and-subtract
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [RR_IW-1:0]  ptr,
                                         input int                n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !res.valid && req[j[RR_IW-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = j[RR_IW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jtframe_sdram_arb_rr.sv
// Rotating priority encoder: picks the first requesting slot at or after ptr.
module jtframe_sdram_arb_rr
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          vld
);

    logic [RR_MAX-1:0] req_ext;
    rr_pick_t          pick;

    // Unused upper request lanes are tied off so they never win
    generate
        for (genvar gi = 0; gi < RR_MAX; gi++) begin : g_ext
            if (gi < N) begin : g_on
                assign req_ext[gi] = req[gi];
            end else begin : g_off
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Rotate-and-encode through the shared helper
    always_comb begin
        pick = rr_pick(req_ext, RR_IW'(ptr), N);
        idx  = PW'(pick.idx);
        vld  = pick.valid;
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Arbiter sharing the board's single SDRAM read port among N ROM requesters.
// One transaction in flight, round-robin grant, per-slot ready strobe.
// Build option: JTFRAME_SDRAM_ARB_PRIO0_EN gives slot 0 absolute priority.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic            clk_rom,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic [N-1:0]    slot_req,
    input  logic [N*AW-1:0] slot_addr,
    output logic [N-1:0]    slot_rdy,
    output logic [DW-1:0]   slot_data,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic [DW-1:0]   data_read,
    input  logic            data_rdy,
    output logic            refresh_en
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    arb_st_t         state_q, state_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            sdram_req_q, sdram_req_d;
    logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
    logic [N-1:0]    slot_rdy_q, slot_rdy_d;
    logic [DW-1:0]   slot_data_q, slot_data_d;

    logic [AW-1:0]   addr_arr [N];
    logic [PW-1:0]   rr_idx, win_idx, ptr_after;
    logic            rr_vld, win_vld;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_addr
            assign addr_arr[gi] = slot_addr[gi*AW +: AW];
        end
    endgenerate

    jtframe_sdram_arb_rr #(.N(N), .PW(PW)) u_rr (
        .req (slot_req),
        .ptr (rr_ptr_q),
        .idx (rr_idx),
        .vld (rr_vld)
    );

    // Winner selection and pointer advance after serving the granted slot
    always_comb begin
        win_idx   = rr_idx;
        win_vld   = rr_vld;
        ptr_after = (gnt_q == PW'(N-1)) ? '0 : gnt_q + 1'b1;
`ifdef JTFRAME_SDRAM_ARB_PRIO0_EN
        if (slot_req[0]) begin
            win_idx = '0;
            win_vld = 1'b1;
        end
        if (gnt_q == '0) ptr_after = rr_ptr_q;
`endif
    end

    // Next-state and datapath updates for the IDLE -> REQ -> WAIT cycle
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_ptr_d     = rr_ptr_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        slot_rdy_d   = '0;
        slot_data_d  = slot_data_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld && !downloading) begin
                    gnt_d        = win_idx;
                    sdram_addr_d = addr_arr[win_idx];
                    sdram_req_d  = 1'b1;
                    state_d      = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    state_d     = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (data_rdy) begin
                    slot_data_d       = data_read;
                    slot_rdy_d[gnt_q] = 1'b1;
                    rr_ptr_d          = ptr_after;
                    state_d           = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            slot_rdy_q   <= '0;
            slot_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            slot_rdy_q   <= slot_rdy_d;
            slot_data_q  <= slot_data_d;
        end
    end

    // Refresh may run only when the port is idle and nobody is waiting for it
    always_comb begin
        refresh_en = rst_n && (state_q == ARB_IDLE) && !(|slot_req) && !downloading;
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign slot_rdy   = slot_rdy_q;
    assign slot_data  = slot_data_q;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb with a small SDRAM controller model.
module tb_jtframe_sdram_arb;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk_rom = 1'b0;
    logic            rst_n = 1'b0;
    logic            downloading = 1'b0;
    logic [N-1:0]    slot_req = '0;
    logic [N*AW-1:0] slot_addr;
    logic [N-1:0]    slot_rdy;
    logic [DW-1:0]   slot_data;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack = 1'b0;
    logic [DW-1:0]   data_read = '0;
    logic            data_rdy = 1'b0;
    logic            refresh_en;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] addr_tab [N];

    jtframe_sdram_arb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_rdy    (slot_rdy),
        .slot_data   (slot_data),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .refresh_en  (refresh_en)
    );

    always #5 clk_rom = ~clk_rom;

    initial begin
        addr_tab[0] = 22'h0A1230;
        addr_tab[1] = 22'h155554;
        addr_tab[2] = 22'h2F00F1;
        addr_tab[3] = 22'h3C0DE5;
    end
    always_comb begin
        for (int i = 0; i < N; i++) slot_addr[i*AW +: AW] = addr_tab[i];
    end

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        return {10'b0, a} ^ 32'hA5A5_0000;
    endfunction

    // Controller model: ack two cycles after a request, data five cycles after ack
    int ctl_cnt  = 0;
    bit ctl_busy = 1'b0;
    always @(negedge clk_rom) begin
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (!rst_n) begin
            ctl_cnt  = 0;
            ctl_busy = 1'b0;
        end else if (!ctl_busy) begin
            if (sdram_req) begin
                ctl_cnt++;
                if (ctl_cnt == 2) begin
                    sdram_ack = 1'b1;
                    ctl_busy  = 1'b1;
                    ctl_cnt   = 0;
                end
            end
        end else begin
            ctl_cnt++;
            if (ctl_cnt == 5) begin
                data_rdy  = 1'b1;
                data_read = model_data(sdram_addr);
                ctl_busy  = 1'b0;
                ctl_cnt   = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for a completion, check slot and data, then check the strobe is one cycle wide.
    // Requesters in drop_mask that were just served drop their request on the ready cycle;
    // reassert_mask bits are raised again one cycle later.
    task automatic expect_txn(input string tag, input int exp_slot,
                              input logic [N-1:0] drop_mask, input logic [N-1:0] reassert_mask);
        bit         seen = 1'b0;
        logic [N-1:0] rdy_seen = '0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk_rom);
            if (slot_rdy != '0) begin
                seen     = 1'b1;
                rdy_seen = slot_rdy;
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            $display("[TB] %s: slot_rdy=%b slot_data=%h", tag, rdy_seen, slot_data);
            chk({tag, "_slot"}, 64'(rdy_seen), 64'(4'b0001 << exp_slot));
            chk({tag, "_data"}, 64'(slot_data), 64'(model_data(addr_tab[exp_slot])));
            slot_req = slot_req & ~(drop_mask & rdy_seen);
            @(negedge clk_rom);
            chk({tag, "_pulse"}, 64'(slot_rdy), 64'd0);
            slot_req = slot_req | reassert_mask;
        end
    endtask

    task automatic wait_req_low(input string tag);
        bit low = 1'b0;
        for (int c = 0; c < 40 && !low; c++) begin
            @(negedge clk_rom);
            if (!sdram_req) low = 1'b1;
        end
        chk({tag, "_wait"}, 64'(low), 64'd1);
    endtask

    int busy_cnt;
    int refr_cnt;
`ifdef JTFRAME_SDRAM_ARB_PRIO0_EN
    int exp5 [5] = '{1, 0, 2, 0, 3};
`else
    int exp5 [5] = '{1, 2, 3, 0, 1};
`endif
    int exp2 [5] = '{0, 1, 2, 3, 0};

    initial begin
        // 1: reset with all requests pending
        slot_req = 4'hF;
        repeat (3) @(negedge clk_rom);
        chk("rst_sdram_req", 64'(sdram_req), 64'd0);
        chk("rst_slot_rdy", 64'(slot_rdy), 64'd0);
        chk("rst_refresh", 64'(refresh_en), 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_data", 64'(slot_data), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_refresh", 64'(refresh_en), 64'd0);
        @(negedge clk_rom);
        chk("rel_sdram_req", 64'(sdram_req), 64'd1);
        chk("rel_addr", 64'(sdram_addr), 64'(addr_tab[0]));
        chk("req_refresh", 64'(refresh_en), 64'd0);

        // 2: round-robin with all requests held
        for (int k = 0; k < 5; k++) expect_txn($sformatf("rr%0d", k), exp2[k], '0, '0);

        // 4: slot 1 (now granted) drops its request while waiting for data
        chk("rr_next_addr", 64'(sdram_addr), 64'(addr_tab[1]));
        wait_req_low("drop");
        chk("wait_refresh", 64'(refresh_en), 64'd0);
        slot_req[1] = 1'b0;
        expect_txn("drop_s1", 1, '0, '0);
        chk("drop_next_req", 64'(sdram_req), 64'd1);
        chk("drop_next_addr", 64'(sdram_addr), 64'(addr_tab[2]));

        // 3: download starts during slot 2's wait
        wait_req_low("dl");
        downloading = 1'b1;
        expect_txn("dl_s2", 2, '0, '0);
        busy_cnt = 0;
        refr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_rom);
            if (sdram_req) busy_cnt++;
            if (refresh_en) refr_cnt++;
        end
        chk("dl_no_grant", 64'(busy_cnt), 64'd0);
        chk("dl_no_refresh", 64'(refr_cnt), 64'd0);
        downloading = 1'b0;
        @(negedge clk_rom);
        chk("dl_end_req", 64'(sdram_req), 64'd1);
        chk("dl_end_addr", 64'(sdram_addr), 64'(addr_tab[3]));

        // 6: everyone withdraws during slot 3's wait, then the port stays idle
        wait_req_low("idle");
        slot_req = '0;
        expect_txn("idle_s3", 3, '0, '0);
        chk("idle_req", 64'(sdram_req), 64'd0);
        busy_cnt = 0;
        refr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_rom);
            if (sdram_req) busy_cnt++;
            if (refresh_en) refr_cnt++;
        end
        chk("idle_no_req", 64'(busy_cnt), 64'd0);
        chk("idle_refresh", 64'(refr_cnt), 64'd20);

        // 5: slots 1-3 held, slot 0 joins and re-requests right after each service
        slot_req = 4'b1110;
        @(negedge clk_rom);
        chk("p_first_addr", 64'(sdram_addr), 64'(addr_tab[1]));
        wait_req_low("p");
        slot_req[0] = 1'b1;
        for (int k = 0; k < 5; k++) expect_txn($sformatf("p%0d", k), exp5[k], 4'b0001, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
